// File: rtl/player_ctrl_wbm_if.sv
// Wishbone link between the player controller (master) and the button peripheral (slave).
interface player_ctrl_wbm_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [7:0]  adr;
   logic [31:0] dat_w;
   logic        sel;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/player_ctrl_wbm.sv
// Per-frame poll of the button peripheral: read buttons, write clamped column,
// write missile-enable mask on a fresh fire press. Keeps shadows of both registers.
module player_ctrl_wbm #(
   parameter int unsigned COL_INIT = 312,
   parameter int unsigned COL_MIN  = 0,
   parameter int unsigned COL_MAX  = 624,
   parameter int unsigned STEP     = 4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic              btn_clk_i,
   input  logic              btn_rst_i,
   input  logic              tick_i,
   input  logic [7:0]        missile_done_i,
   player_ctrl_wbm_if.master wbm,
   output logic [11:0]       player_col_o,
   output logic [7:0]        missile_o,
   output logic              busy_o,
   output logic              err_o,
   output logic              overrun_o
);
   localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [7:0]  ADR_BTN = 8'h00;
   localparam logic [7:0]  ADR_COL = 8'h04;
   localparam logic [7:0]  ADR_MSL = 8'h08;

   typedef enum logic [2:0] {IDLE, RD_BTN, GAP1, WR_COL, GAP2, WR_MSL} state_t;

   state_t             state_q, state_d;
   logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [7:0]         adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [11:0]        col_q, col_d, new_col_q, new_col_d;
   logic [7:0]         msl_q, msl_d, set_q, set_d, msl_or, low_zero;
   logic               fire_q, fire_d, prev_q, prev_d, pend_q, pend_d;
   logic               busy_q, busy_d, err_q, err_d, ovr_q, ovr_d;
   logic               acc_ok, abort;
   logic [12:0]        col_calc;
   logic               unused_bits_c;

   assign unused_bits_c = ^{wbm.dat_r[31:5], wbm.dat_r[3], wbm.dat_r[0]};

   always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
      if (btn_rst_i) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         cnt_q     <= '0;
         col_q     <= 12'(COL_INIT);
         new_col_q <= 12'(COL_INIT);
         msl_q     <= '0;
         set_q     <= '0;
         fire_q    <= 1'b0;
         prev_q    <= 1'b0;
         pend_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         cnt_q     <= cnt_d;
         col_q     <= col_d;
         new_col_q <= new_col_d;
         msl_q     <= msl_d;
         set_q     <= set_d;
         fire_q    <= fire_d;
         prev_q    <= prev_d;
         pend_q    <= pend_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      cnt_d     = cnt_q;
      col_d     = col_q;
      new_col_d = new_col_q;
      set_d     = set_q;
      fire_d    = fire_q;
      prev_d    = prev_q;
      pend_d    = pend_q;
      err_d     = err_q;
      ovr_d     = ovr_q;
      msl_or    = '0;
      low_zero  = ~msl_q & (msl_q + 8'd1);
      acc_ok    = stb_q & wbm.ack & ~wbm.err;
      abort     = stb_q & (wbm.err | (~wbm.ack & (cnt_q == CNT_W'(TIMEOUT - 1))));

      if (stb_q) cnt_d = cnt_q + CNT_W'(1);

      // Clamped column update; dat_r[2] = BTNL, dat_r[1] = BTNR
      col_calc = 13'(col_q);
      if (wbm.dat_r[2] && !wbm.dat_r[1]) begin
         if (13'(col_q) < 13'(COL_MIN + STEP)) col_calc = 13'(COL_MIN);
         else                                  col_calc = 13'(col_q) - 13'(STEP);
      end else if (wbm.dat_r[1] && !wbm.dat_r[2]) begin
         if (13'(col_q) + 13'(STEP) > 13'(COL_MAX)) col_calc = 13'(COL_MAX);
         else                                       col_calc = 13'(col_q) + 13'(STEP);
      end

      case (state_q)
         IDLE: begin
            if (tick_i || pend_q) begin
               pend_d  = 1'b0;
               state_d = RD_BTN;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = ADR_BTN;
               dat_d   = '0;
               cnt_d   = '0;
            end
         end
         RD_BTN: begin
            if (acc_ok) begin
               new_col_d = 12'(col_calc);
               fire_d    = wbm.dat_r[4] & ~prev_q;
               prev_d    = wbm.dat_r[4];
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               state_d   = GAP1;
            end
         end
         GAP1: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = ADR_COL;
            dat_d   = 32'(new_col_q);
            cnt_d   = '0;
            state_d = WR_COL;
         end
         WR_COL: begin
            if (acc_ok) begin
               col_d   = new_col_q;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               state_d = GAP2;
            end
         end
         GAP2: begin
            if (fire_q && msl_q != 8'hFF) begin
               set_d   = low_zero;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = ADR_MSL;
               dat_d   = 32'(msl_q | low_zero);
               cnt_d   = '0;
               state_d = WR_MSL;
            end else begin
               state_d = IDLE;
            end
         end
         WR_MSL: begin
            // One strobe-low tail cycle after the ack before returning to idle
            if (acc_ok) begin
               msl_or = set_q;
               cyc_d  = 1'b0;
               stb_d  = 1'b0;
            end else if (!stb_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         err_d   = 1'b1;
         state_d = IDLE;
      end

      if (tick_i && state_q != IDLE) begin
         if (pend_q) ovr_d  = 1'b1;
         else        pend_d = 1'b1;
      end

      // Completion clears take priority over the committed set bit
      msl_d  = (msl_q | msl_or) & ~missile_done_i;
      busy_d = (state_d != IDLE);
   end

   assign wbm.cyc      = cyc_q;
   assign wbm.stb      = stb_q;
   assign wbm.we       = we_q;
   assign wbm.adr      = adr_q;
   assign wbm.dat_w    = dat_q;
   assign wbm.sel      = stb_q;
   assign player_col_o = col_q;
   assign missile_o    = msl_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_player_ctrl_wbm.sv
// Directed bench for player_ctrl_wbm with a 1-wait-state Wishbone target model.
module tb_player_ctrl_wbm;
   logic        btn_clk_i = 1'b0;
   logic        btn_rst_i;
   logic        tick_i;
   logic [7:0]  missile_done_i;
   logic [11:0] player_col_o;
   logic [7:0]  missile_o;
   logic        busy_o, err_o, overrun_o;

   logic        tgt_ack_en, tgt_err_en;
   logic [31:0] rd_data;
   logic [31:0] s_tr, b_tr;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  log_adr[$];
   logic [31:0] log_dat[$];
   logic        log_we[$];
   logic        log_sel[$];

   player_ctrl_wbm_if wb ();

   player_ctrl_wbm dut (
      .btn_clk_i      (btn_clk_i),
      .btn_rst_i      (btn_rst_i),
      .tick_i         (tick_i),
      .missile_done_i (missile_done_i),
      .wbm            (wb),
      .player_col_o   (player_col_o),
      .missile_o      (missile_o),
      .busy_o         (busy_o),
      .err_o          (err_o),
      .overrun_o      (overrun_o)
   );

   always #5 btn_clk_i = ~btn_clk_i;

   assign wb.dat_r = rd_data;

   // Target: acks any strobed cycle that does not directly follow its own response
   always @(posedge btn_clk_i or posedge btn_rst_i) begin
      if (btn_rst_i) begin
         wb.ack <= 1'b0;
         wb.err <= 1'b0;
      end else begin
         wb.ack <= tgt_ack_en && wb.stb && !wb.ack && !wb.err;
         wb.err <= tgt_err_en && wb.stb && !wb.ack && !wb.err;
         if (wb.stb && wb.ack) begin
            log_adr.push_back(wb.adr);
            log_dat.push_back(wb.dat_w);
            log_we.push_back(wb.we);
            log_sel.push_back(wb.sel);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_acc(input string tag, input int idx, input logic we,
                            input logic [7:0] adr, input logic [31:0] dat);
      if (idx >= log_adr.size()) begin
         check({tag, "_present"}, 32'(log_adr.size()), 32'(idx + 1));
      end else begin
         check({tag, "_adr"}, 32'(log_adr[idx]), 32'(adr));
         check({tag, "_we"}, 32'(log_we[idx]), 32'(we));
         check({tag, "_sel"}, 32'(log_sel[idx]), 32'd1);
         if (we) check({tag, "_dat"}, log_dat[idx], dat);
      end
   endtask

   task automatic log_clear();
      log_adr.delete();
      log_dat.delete();
      log_we.delete();
      log_sel.delete();
   endtask

   // One tick-started poll; records stb and busy per cycle (cycle 0 = tick cycle)
   task automatic poll(input logic [31:0] rd);
      rd_data = rd;
      log_clear();
      s_tr = '0;
      b_tr = '0;
      @(negedge btn_clk_i) tick_i = 1'b1;
      @(negedge btn_clk_i) tick_i = 1'b0;
      for (int k = 1; k < 64; k++) begin
         if (k < 32) begin
            s_tr[k] = wb.stb;
            b_tr[k] = busy_o;
         end
         if (!busy_o) break;
         @(negedge btn_clk_i);
      end
      if (busy_o) check("poll_timeout", 32'(busy_o), 32'd0);
   endtask

   task automatic done_pulse(input logic [7:0] m);
      @(negedge btn_clk_i) missile_done_i = m;
      @(negedge btn_clk_i) missile_done_i = 8'h00;
   endtask

   initial begin
      int reads;
      btn_rst_i      = 1'b1;
      tick_i         = 1'b0;
      missile_done_i = 8'h00;
      tgt_ack_en     = 1'b1;
      tgt_err_en     = 1'b0;
      rd_data        = '0;
      repeat (3) @(negedge btn_clk_i);
      btn_rst_i = 1'b0;
      @(negedge btn_clk_i);
      check("rst_cyc", 32'(wb.cyc), 32'd0);
      check("rst_stb", 32'(wb.stb), 32'd0);
      check("rst_col", 32'(player_col_o), 32'd312);
      check("rst_msl", 32'(missile_o), 32'h00);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ovr", 32'(overrun_o), 32'd0);

      poll(32'h04);
      check("left_stb_trace", s_tr, 32'h0000_0036);
      check("left_busy_trace", b_tr, 32'h0000_007E);
      check("left_nacc", 32'(log_adr.size()), 32'd2);
      check_acc("left_rd", 0, 1'b0, 8'h00, 32'h0);
      check_acc("left_wr", 1, 1'b1, 8'h04, 32'd308);
      check("left_col", 32'(player_col_o), 32'd308);

      poll(32'h0D);
      check("uld_col", 32'(player_col_o), 32'd304);
      check_acc("uld_wr", 1, 1'b1, 8'h04, 32'd304);

      for (int i = 0; i < 80; i++) poll(32'h04);
      check("floor_col", 32'(player_col_o), 32'd0);
      check_acc("floor_wr", 1, 1'b1, 8'h04, 32'd0);

      for (int i = 0; i < 160; i++) poll(32'h02);
      check("cap_col", 32'(player_col_o), 32'd624);
      check_acc("cap_wr", 1, 1'b1, 8'h04, 32'd624);

      poll(32'h06);
      check("lr_col", 32'(player_col_o), 32'd624);
      check("lr_nacc", 32'(log_adr.size()), 32'd2);
      check_acc("lr_wr", 1, 1'b1, 8'h04, 32'd624);

      poll(32'h0D);
      check("uld2_col", 32'(player_col_o), 32'd620);

      poll(32'h10);
      check("fire1_stb_trace", s_tr, 32'h0000_01B6);
      check("fire1_busy_trace", b_tr, 32'h0000_03FE);
      check("fire1_nacc", 32'(log_adr.size()), 32'd3);
      check_acc("fire1_wr", 2, 1'b1, 8'h08, 32'h01);
      check("fire1_msl", 32'(missile_o), 32'h01);
      poll(32'h10);
      check("hold_nacc", 32'(log_adr.size()), 32'd2);
      poll(32'h00);
      check("rel_nacc", 32'(log_adr.size()), 32'd2);
      poll(32'h10);
      check("fire2_nacc", 32'(log_adr.size()), 32'd3);
      check_acc("fire2_wr", 2, 1'b1, 8'h08, 32'h03);
      check("fire2_msl", 32'(missile_o), 32'h03);

      done_pulse(8'h01);
      check("done0_msl", 32'(missile_o), 32'h02);
      poll(32'h00);
      poll(32'h10);
      check_acc("refill_wr", 2, 1'b1, 8'h08, 32'h03);
      check("refill_msl", 32'(missile_o), 32'h03);

      poll(32'h00);
      missile_done_i = 8'h04;
      poll(32'h10);
      missile_done_i = 8'h00;
      check_acc("clrwin_wr", 2, 1'b1, 8'h08, 32'h07);
      check("clrwin_msl", 32'(missile_o), 32'h03);

      for (int i = 0; i < 6; i++) begin
         poll(32'h00);
         poll(32'h10);
      end
      check("full_msl", 32'(missile_o), 32'hFF);
      poll(32'h00);
      poll(32'h10);
      check("full_nacc", 32'(log_adr.size()), 32'd2);
      check("full_msl2", 32'(missile_o), 32'hFF);
      done_pulse(8'hFF);
      check("clrall_msl", 32'(missile_o), 32'h00);

      tgt_ack_en = 1'b0;
      poll(32'h04);
      check("to_stb_trace", s_tr, 32'h0001_FFFE);
      check("to_busy_trace", b_tr, 32'h0001_FFFE);
      check("to_err", 32'(err_o), 32'd1);
      check("to_col", 32'(player_col_o), 32'd620);
      check("to_nacc", 32'(log_adr.size()), 32'd0);
      tgt_ack_en = 1'b1;
      poll(32'h04);
      check("retry_col", 32'(player_col_o), 32'd616);
      check_acc("retry_wr", 1, 1'b1, 8'h04, 32'd616);
      check("retry_err", 32'(err_o), 32'd1);

      tgt_ack_en = 1'b0;
      tgt_err_en = 1'b1;
      poll(32'h04);
      tgt_err_en = 1'b0;
      tgt_ack_en = 1'b1;
      check("werr_stb_trace", s_tr, 32'h0000_0006);
      check("werr_col", 32'(player_col_o), 32'd616);
      check("werr_nacc", 32'(log_adr.size()), 32'd0);
      check("pre_ovr", 32'(overrun_o), 32'd0);

      rd_data = 32'h00;
      log_clear();
      @(negedge btn_clk_i) tick_i = 1'b1;
      @(negedge btn_clk_i) tick_i = 1'b0;
      @(negedge btn_clk_i) tick_i = 1'b1;
      @(negedge btn_clk_i) tick_i = 1'b0;
      @(negedge btn_clk_i) tick_i = 1'b1;
      @(negedge btn_clk_i) tick_i = 1'b0;
      repeat (30) @(negedge btn_clk_i);
      reads = 0;
      foreach (log_adr[i]) if (log_adr[i] == 8'h00 && !log_we[i]) reads++;
      check("ovr_reads", 32'(reads), 32'd2);
      check("ovr_flag", 32'(overrun_o), 32'd1);
      check("ovr_idle", 32'(busy_o), 32'd0);

      poll(32'h00);
      poll(32'h10);
      check("prerst_msl", 32'(missile_o), 32'h01);
      rd_data = 32'h02;
      @(negedge btn_clk_i) tick_i = 1'b1;
      @(negedge btn_clk_i) tick_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (wb.stb && wb.we) break;
         @(negedge btn_clk_i);
      end
      check("rst_in_write", 32'(wb.stb && wb.we), 32'd1);
      #2 btn_rst_i = 1'b1;
      #1;
      check("mid_rst_cyc", 32'(wb.cyc), 32'd0);
      check("mid_rst_stb", 32'(wb.stb), 32'd0);
      check("mid_rst_col", 32'(player_col_o), 32'd312);
      check("mid_rst_msl", 32'(missile_o), 32'h00);
      check("mid_rst_flags", {29'd0, busy_o, err_o, overrun_o}, 32'd0);
      @(negedge btn_clk_i) btn_rst_i = 1'b0;
      repeat (2) @(negedge btn_clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
